vec_store_serializer: RTL

//  Writeback end of the 6-lane vector ALU datapath. Accepts one packed result

---
 rtl/vec_store_serializer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vec_store_serializer.sv
// vec_store_serializer
//   Writeback end of the vector ALU datapath. Captures one packed result word
//   and issues it to data memory as single-lane stores with incrementing
//   addresses (lane 0 first). Scalar words store lane 0 only. All outputs come
//   straight from registers.
//   Optional build macro: VEC_STORE_ZERO_SKIP_EN -- lanes whose data is zero
//   are skipped (mem_we low for one cycle, no wait on mem_ready).
module vec_store_serializer #(
  parameter int LANES       = 6,
  parameter int LANE_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_vec,
  input  logic                      in_scalar,
  input  logic [ADDR_W-1:0]         in_base_addr,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LANE_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int                LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0]     LAST_LANE = LW'(LANES - 1);
  localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(ADDR_STRIDE);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Next lane address; the sum is truncated so it wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] a);
    return a + STRIDE;
  endfunction

  state_t              state, state_d;
  logic [LW-1:0]       lane_p0, lane_d;
  logic [LW-1:0]       last_p0, last_d;
  logic [LANE_W-1:0]   lanes_p0 [LANES];
  logic                capture;

  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [LANE_W-1:0]   mem_wdata_d;
  logic                busy_d;
  logic                done_d;
  logic                in_ready_d;

  logic [LW-1:0]       lane_inc;
  logic [LANE_W-1:0]   first_lane;
  logic [LANE_W-1:0]   next_lane;
  logic                first_en;
  logic                next_en;
  logic                advance;

  // Next-state and next-output logic; outputs are precomputed here and
  // registered so nothing combinational reaches a port.
  always_comb begin
    state_d     = state;
    lane_d      = lane_p0;
    last_d      = last_p0;
    capture     = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    busy_d      = busy;
    done_d      = 1'b0;
    in_ready_d  = in_ready;

    lane_inc   = lane_p0 + LW'(1);
    first_lane = in_vec[LANE_W-1:0];
    next_lane  = lanes_p0[lane_inc];
`ifdef VEC_STORE_ZERO_SKIP_EN
    first_en   = |first_lane;
    next_en    = |next_lane;
`else
    first_en   = 1'b1;
    next_en    = 1'b1;
`endif
    // A skipped lane (mem_we low while sending) moves on without a handshake.
    advance = mem_ready | ~mem_we;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          capture     = 1'b1;
          state_d     = SEND;
          lane_d      = '0;
          last_d      = in_scalar ? '0 : LAST_LANE;
          mem_we_d    = first_en;
          mem_addr_d  = in_base_addr;
          mem_wdata_d = first_lane;
          busy_d      = 1'b1;
          in_ready_d  = 1'b0;
        end
      end
      SEND: begin
        if (advance) begin
          if (lane_p0 == last_p0) begin
            state_d    = IDLE;
            mem_we_d   = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            in_ready_d = 1'b1;
          end else begin
            lane_d      = lane_inc;
            mem_we_d    = next_en;
            mem_addr_d  = addr_step(mem_addr);
            mem_wdata_d = next_lane;
          end
        end
      end
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lane_p0   <= '0;
      last_p0   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_d;
      lane_p0   <= lane_d;
      last_p0   <= last_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
      done      <= done_d;
      in_ready  <= in_ready_d;
    end
  end

  // Capture stage: hold the accepted word so upstream may change in_vec.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < LANES; k++) begin
        lanes_p0[k] <= in_vec[k*LANE_W +: LANE_W];
      end
    end
  end

endmodule
